cb_group_scan_ctrl: RTL and testbench

- Sequences the CB base-address generator over a run of covariance-bank groups for one EKF-SLAM sweep.
- Per group it:
  - drives the generator's enable and group index;
  - waits the generator's pipeline latency;
  - captures the base address;
  - emits ROWS_PER_GROUP row-start addresses over a valid/ready stream.
- Sits between the EKF top-level sequencer (start/done) and the CB read/write address path.

---
 rtl/cb_group_scan_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_cb_group_scan_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/cb_group_scan_ctrl.sv
// Drives the CB base-address generator group by group and streams row-start addresses.
// Optional CB_SCAN_PREFETCH_EN overlaps the next group's generator latency with the current burst.
module cb_group_scan_ctrl #(
  parameter  int CB_AW          = 17,
  parameter  int ROW_LEN        = 10,
  parameter  int AGD_LAT        = 4,
  parameter  int ROWS_PER_GROUP = 4,
  parameter  int ROW_STRIDE     = 4,
  localparam int RW             = $clog2(ROWS_PER_GROUP) + 1
) (
  input  logic               clk,
  input  logic               sys_rst,
  input  logic               start,
  input  logic               abort,
  input  logic [ROW_LEN-1:0] num_groups,
  output logic               agd_en,
  output logic [ROW_LEN-1:0] agd_group_cnt,
  input  logic [CB_AW-1:0]   agd_base_addr,
  output logic               addr_valid,
  input  logic               addr_ready,
  output logic [CB_AW-1:0]   addr,
  output logic [ROW_LEN-1:0] addr_group,
  output logic [RW-1:0]      addr_row,
  output logic               addr_last,
  output logic               busy,
  output logic               done
);
  localparam int LW = $clog2(AGD_LAT + 2);

  typedef enum logic [1:0] {IDLE, CALC, BURST, FIN} state_e;

  state_e             state_q;
  logic [ROW_LEN-1:0] ng_q, grp_q, agd_grp_q;
  logic [RW-1:0]      row_q;
  logic [LW-1:0]      lat_q;
  logic [CB_AW-1:0]   base_q;
  logic               agd_en_q, busy_q, done_q;

  logic               row_last, grp_last, lat_hit;
  logic [ROW_LEN-1:0] grp_nxt;

  assign row_last = (row_q == RW'(ROWS_PER_GROUP - 1));
  assign grp_last = (grp_q == ng_q - ROW_LEN'(1));
  assign lat_hit  = (lat_q == LW'(AGD_LAT));
  assign grp_nxt  = grp_q + ROW_LEN'(1);

`ifdef CB_SCAN_PREFETCH_EN
  logic             pf_run_q, pf_vld_q, pf_hit, nxt_last;
  logic [CB_AW-1:0] nxt_base_q;
  assign pf_hit   = pf_run_q && lat_hit;
  assign nxt_last = (grp_nxt == ng_q - ROW_LEN'(1));
`endif

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state_q   <= IDLE;
      ng_q      <= '0;
      grp_q     <= '0;
      agd_grp_q <= '0;
      row_q     <= '0;
      lat_q     <= '0;
      base_q    <= '0;
      agd_en_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef CB_SCAN_PREFETCH_EN
      pf_run_q   <= 1'b0;
      pf_vld_q   <= 1'b0;
      nxt_base_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      if (abort && state_q != IDLE) begin
        // cancel wins over any coincident handshake; no done for an aborted sweep
        state_q  <= IDLE;
        agd_en_q <= 1'b0;
        busy_q   <= 1'b0;
`ifdef CB_SCAN_PREFETCH_EN
        pf_run_q <= 1'b0;
        pf_vld_q <= 1'b0;
`endif
      end else begin
        unique case (state_q)
          IDLE: if (start && !abort) begin
            ng_q   <= num_groups;
            grp_q  <= '0;
            busy_q <= 1'b1;
            if (num_groups == '0) begin
              state_q <= FIN;
            end else begin
              state_q   <= CALC;
              agd_en_q  <= 1'b1;
              agd_grp_q <= '0;
              lat_q     <= '0;
            end
          end
          CALC: begin
            lat_q <= lat_q + LW'(1);
            if (lat_hit) begin
              base_q  <= agd_base_addr;
              row_q   <= '0;
              state_q <= BURST;
`ifdef CB_SCAN_PREFETCH_EN
              if (!grp_last) begin
                agd_grp_q <= grp_nxt;
                lat_q     <= '0;
                pf_run_q  <= 1'b1;
              end else begin
                agd_en_q <= 1'b0;
                pf_run_q <= 1'b0;
              end
`else
              agd_en_q <= 1'b0;
`endif
            end
          end
          BURST: begin
`ifdef CB_SCAN_PREFETCH_EN
            if (pf_run_q) lat_q <= lat_q + LW'(1);
            if (pf_hit) begin
              nxt_base_q <= agd_base_addr;
              pf_vld_q   <= 1'b1;
              pf_run_q   <= 1'b0;
              agd_en_q   <= 1'b0;
            end
`endif
            if (addr_ready) begin
              row_q <= row_q + RW'(1);
              if (row_last) begin
                if (grp_last) begin
                  state_q <= FIN;
                end else begin
                  grp_q <= grp_nxt;
`ifdef CB_SCAN_PREFETCH_EN
                  // later assignments here override the prefetch capture above
                  if (pf_vld_q || pf_hit) begin
                    base_q   <= pf_vld_q ? nxt_base_q : agd_base_addr;
                    row_q    <= '0;
                    pf_vld_q <= 1'b0;
                    if (!nxt_last) begin
                      agd_en_q  <= 1'b1;
                      agd_grp_q <= grp_nxt + ROW_LEN'(1);
                      lat_q     <= '0;
                      pf_run_q  <= 1'b1;
                    end else begin
                      agd_en_q <= 1'b0;
                      pf_run_q <= 1'b0;
                    end
                  end else begin
                    state_q <= CALC;
                  end
`else
                  state_q   <= CALC;
                  agd_en_q  <= 1'b1;
                  agd_grp_q <= grp_nxt;
                  lat_q     <= '0;
`endif
                end
              end
            end
          end
          FIN: begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign agd_en        = agd_en_q;
  assign agd_group_cnt = agd_grp_q;
  assign addr_valid    = (state_q == BURST);
  assign addr          = base_q + CB_AW'(int'(row_q) * ROW_STRIDE);
  assign addr_group    = grp_q;
  assign addr_row      = row_q;
  assign addr_last     = (state_q == BURST) && row_last && grp_last;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_cb_group_scan_ctrl.sv
// Scoreboard bench for cb_group_scan_ctrl with a latency-accurate generator model.
module tb_cb_group_scan_ctrl;
  localparam int CB_AW = 17, ROW_LEN = 10, AGD_LAT = 4, RPG = 4, STRIDE = 4;
  localparam int RW = $clog2(RPG) + 1;
`ifdef CB_SCAN_PREFETCH_EN
  localparam int GAP = (AGD_LAT + 1 > RPG) ? AGD_LAT + 1 - RPG : 0;
`else
  localparam int GAP = AGD_LAT + 1;
`endif

  logic               clk = 0, sys_rst = 1, start = 0, abort = 0, addr_ready = 0;
  logic [ROW_LEN-1:0] num_groups = '0;
  logic               agd_en, addr_valid, addr_last, busy, done;
  logic [ROW_LEN-1:0] agd_group_cnt, addr_group;
  logic [CB_AW-1:0]   agd_base_addr, addr;
  logic [RW-1:0]      addr_row;

  cb_group_scan_ctrl #(.CB_AW(CB_AW), .ROW_LEN(ROW_LEN), .AGD_LAT(AGD_LAT),
                       .ROWS_PER_GROUP(RPG), .ROW_STRIDE(STRIDE)) dut (
    .clk(clk), .sys_rst(sys_rst), .start(start), .abort(abort), .num_groups(num_groups),
    .agd_en(agd_en), .agd_group_cnt(agd_group_cnt), .agd_base_addr(agd_base_addr),
    .addr_valid(addr_valid), .addr_ready(addr_ready), .addr(addr), .addr_group(addr_group),
    .addr_row(addr_row), .addr_last(addr_last), .busy(busy), .done(done));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, cyc = 0;
  int done_cnt, done_cyc, en_cnt, vld_cnt, hs_cnt, first_cyc, last_cyc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // generator: base = 2*(g+1)*(g+2), valid after AGD_LAT edges with en high and group stable
  function automatic logic [CB_AW-1:0] gen_base(input int g);
    return CB_AW'(2 * (g + 1) * (g + 2));
  endfunction

  int                 gcnt = 0;
  logic [ROW_LEN-1:0] gseen = '0;
  always @(posedge clk) begin
    if (!agd_en) gcnt <= 0;
    else if (gcnt == 0 || agd_group_cnt == gseen) gcnt <= gcnt + 1;
    else gcnt <= 1;
    gseen <= agd_group_cnt;
  end
  assign agd_base_addr = (agd_en && gcnt >= AGD_LAT && agd_group_cnt == gseen)
                         ? gen_base(int'(agd_group_cnt)) : CB_AW'('h1abcd);

  typedef struct {
    logic [CB_AW-1:0]   a;
    logic [ROW_LEN-1:0] g;
    logic [RW-1:0]      r;
    logic               l;
  } exp_t;
  exp_t q[$];

  task automatic push_sweep(input int ng, input int keep_groups);
    exp_t e;
    for (int g = 0; g < keep_groups; g++)
      for (int r = 0; r < RPG; r++) begin
        e.a = gen_base(g) + CB_AW'(r * STRIDE);
        e.g = ROW_LEN'(g);
        e.r = RW'(r);
        e.l = (g == ng - 1) && (r == RPG - 1);
        q.push_back(e);
      end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (!sys_rst) begin
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (agd_en) en_cnt++;
    if (addr_valid) begin
      vld_cnt++;
      if (q.size() == 0) chk("sb_empty", 1, 0);
      else begin
        chk("addr", 32'(addr), 32'(q[0].a));
        chk("addr_group", 32'(addr_group), 32'(q[0].g));
        chk("addr_row", 32'(addr_row), 32'(q[0].r));
        chk("addr_last", 32'(addr_last), 32'(q[0].l));
        if (addr_ready) begin
          void'(q.pop_front());
          hs_cnt++;
          if (hs_cnt == 1) first_cyc = cyc;
          last_cyc = cyc;
        end
      end
    end
  end

  int start_cyc;
  task automatic clr();
    done_cnt = 0; en_cnt = 0; vld_cnt = 0; hs_cnt = 0; first_cyc = 0; last_cyc = 0; done_cyc = 0;
  endtask

  // bp: ready pattern 1,0,0,1; rs_ng>0: re-issue start once a burst is running
  task automatic run_sweep(input int ng, input bit bp, input int rs_ng);
    bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    bit fired = 0;
    push_sweep(ng, ng);
    clr();
    @(posedge clk); #1;
    num_groups = ROW_LEN'(ng); start = 1; start_cyc = cyc;
    @(posedge clk); #1;
    start = 0;
    chk("busy_on", 32'(busy), 1);
    for (int k = 0; k < 3000 && done_cnt == 0; k++) begin
      addr_ready = bp ? pat[k % 4] : 1'b1;
      if (rs_ng > 0 && !fired && addr_valid) begin
        start = 1; num_groups = ROW_LEN'(rs_ng); fired = 1;
      end else start = 0;
      @(posedge clk); #1;
    end
    start = 0; addr_ready = 1;
    chk("done_seen", 32'(done_cnt > 0), 1);
    repeat (3) @(posedge clk);
    #1;
    chk("done_once", 32'(done_cnt), 1);
    chk("sb_drained", 32'(q.size()), 0);
    chk("busy_off", 32'(busy), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_agd_en", 32'(agd_en), 0);
    chk("rst_agd_grp", 32'(agd_group_cnt), 0);
    chk("rst_valid", 32'(addr_valid), 0);
    chk("rst_addr", 32'(addr), 0);
    chk("rst_row_grp", 32'({addr_row, addr_group}), 0);
    chk("rst_flags", 32'({addr_last, busy, done}), 0);
    sys_rst = 0;

    // basic sweep, 3 groups
    run_sweep(3, 0, 0);
    chk("basic_hs", 32'(hs_cnt), 12);
    chk("basic_span", 32'(last_cyc - first_cyc), 32'(11 + 2 * GAP));
    chk("basic_done_lat", 32'(done_cyc - last_cyc), 2);
`ifndef CB_SCAN_PREFETCH_EN
    chk("basic_en_cycles", 32'(en_cnt), 32'(3 * (AGD_LAT + 1)));
`endif

    // backpressure, 1 group
    run_sweep(1, 1, 0);
    chk("bp_hs", 32'(hs_cnt), 4);

    // zero groups
    run_sweep(0, 0, 0);
    chk("zero_done_lat", 32'(done_cyc - start_cyc), 2);
    chk("zero_en", 32'(en_cnt), 0);
    chk("zero_vld", 32'(vld_cnt), 0);

    // abort during CALC of group 1
    begin
      bit hit = 0;
      push_sweep(4, 1);
      clr();
      addr_ready = 1;
      @(posedge clk); #1;
      num_groups = 4; start = 1;
      @(posedge clk); #1;
      start = 0;
      for (int k = 0; k < 200 && !hit; k++) begin
        if (agd_en && agd_group_cnt == 1 && !addr_valid) hit = 1;
        else begin @(posedge clk); #1; end
      end
      chk("abort_reached", 32'(hit), 1);
      abort = 1;
      @(posedge clk); #1;
      abort = 0;
      chk("abort_agd_en", 32'(agd_en), 0);
      chk("abort_busy", 32'(busy), 0);
      repeat (20) @(posedge clk);
      #1;
      chk("abort_no_done", 32'(done_cnt), 0);
      chk("abort_vld", 32'(vld_cnt), 4);
      chk("abort_sb", 32'(q.size()), 0);
    end
    run_sweep(1, 0, 0);
    chk("post_abort_hs", 32'(hs_cnt), 4);

    // start while busy is ignored
    run_sweep(2, 0, 7);
    chk("restart_hs", 32'(hs_cnt), 8);
    chk("restart_span", 32'(last_cyc - first_cyc), 32'(7 + GAP));

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
